// File: rtl/pe_sum_collector.sv
// pe_sum_collector: accumulates fusion-unit partial sums over a job of
// len operand beats, starting from bias. Each accepted beat returns a
// PE_sum LAT cycles later; that value becomes the new accumulator, which
// is fed back to the adder tree as previous_sum.
//
// state | meaning
// IDLE  | no job; waiting for start
// ACC   | issuing operand beats (in_ready while issued < len)
// DRAIN | all beats issued; waiting for outstanding returns
// OUT   | result presented on out_sum until out_ready
module pe_sum_collector #(
  parameter int SUM_W = 20,
  parameter int LAT   = 1,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [SUM_W-1:0] bias,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SUM_W-1:0] previous_sum,
  input  logic [SUM_W-1:0] PE_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;

  state_t           state;
  logic [SUM_W-1:0] acc;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued;
  logic [LEN_W-1:0] received;
  logic [LEN_W-1:0] issued_nxt;
  logic [LEN_W-1:0] received_nxt;
  logic [LAT-1:0]   vld_sr;
  logic             beat;
  logic             ret;
  logic             start_acc;

  // Outputs are pure decodes of registered state, so they follow reset at once.
  assign in_ready     = (state == ACC) && (issued < len_q);
  assign beat         = in_valid && in_ready;
  assign ret          = vld_sr[LAT-1];
  assign start_acc    = start && ((state == IDLE) || ((state == OUT) && out_ready));
  assign previous_sum = acc;
  assign out_sum      = acc;
  assign out_valid    = (state == OUT);
  assign busy         = (state != IDLE);

  // Counter values after this cycle's issue/return, used for exit decisions.
  always_comb begin
    issued_nxt   = issued + LEN_W'(beat);
    received_nxt = received + LEN_W'(ret);
  end

  // Job FSM, counters, accumulator and in-flight beat pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      acc      <= '0;
      len_q    <= '0;
      issued   <= '0;
      received <= '0;
      vld_sr   <= '0;
    end else if (start_acc) begin
      // A new job flushes anything still in the pipeline.
      acc      <= bias;
      len_q    <= len;
      issued   <= '0;
      received <= '0;
      vld_sr   <= '0;
      state    <= (len == '0) ? OUT : ACC;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        vld_sr[i] <= vld_sr[i-1];
      end
      vld_sr[0] <= beat;
      issued    <= issued_nxt;
      received  <= received_nxt;
      if (ret) begin
        acc <= PE_sum;
      end
      case (state)
        ACC: begin
          if (issued_nxt == len_q) begin
            state <= (received_nxt == len_q) ? OUT : DRAIN;
          end
        end
        DRAIN: begin
          if (received_nxt == len_q) begin
            state <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
